// File: rtl/mem_load_unit.sv
// Single-read load unit: one byte-addressed memory read per request. The read
// word is turned into a word, an extended halfword/byte, or an exception vector.
module mem_load_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mode,
  input  logic [31:0] addr,
  input  logic [1:0]  exc_sel,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata
);

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [31:0] eff_reg, eff_next;
  logic [2:0]  mode_reg, mode_next;
  logic        fault_reg, fault_next;
  logic [31:0] rdata_reg, rdata_next;

  logic        req_legal;
  logic [31:0] req_eff;
  logic [7:0]  byte_lane [4];
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] extracted;

  // Request decode: legality and effective byte address.
  always_comb begin
    req_legal = 1'b1;
    req_eff   = addr;
    case (mode)
      3'b000:         req_legal = (addr[1:0] == 2'b00);
      3'b001, 3'b010: req_legal = (addr[0] == 1'b0);
      3'b011, 3'b100: req_legal = 1'b1;
      3'b101: begin
        case (exc_sel)
          2'b00:   req_eff = 32'h0000_00FD;
          2'b01:   req_eff = 32'h0000_00FE;
          2'b10:   req_eff = 32'h0000_00FF;
          default: req_legal = 1'b0;
        endcase
      end
      default:        req_legal = 1'b0;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_lane[gi] = mem_rdata[8*gi +: 8];
  end

  assign lane_byte = byte_lane[eff_reg[1:0]];
  assign lane_half = eff_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (mode_reg)
      3'b000:         extracted = mem_rdata;
      3'b001:         extracted = {{16{lane_half[15]}}, lane_half};
      3'b010:         extracted = {16'h0000, lane_half};
      3'b011:         extracted = {{24{lane_byte[7]}}, lane_byte};
      3'b100, 3'b101: extracted = {24'h000000, lane_byte};
      default:        extracted = 32'h0000_0000;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    eff_next   = eff_reg;
    mode_next  = mode_reg;
    fault_next = fault_reg;
    rdata_next = rdata_reg;
    mem_rd     = 1'b0;
    mem_addr   = 32'h0000_0000;
    busy       = 1'b1;
    done       = 1'b0;
    fault      = 1'b0;
    case (state_reg)
      IDLE: begin
        busy     = 1'b0;
        cnt_next = 3'd0;
        if (start) begin
          if (req_legal) begin
            eff_next   = req_eff;
            mode_next  = mode;
            fault_next = 1'b0;
            cnt_next   = 3'd1;
            state_next = REQ;
          end else begin
            // Illegal requests skip memory entirely and report at once.
            fault_next = 1'b1;
            rdata_next = 32'h0000_0000;
            state_next = DONE;
          end
        end
      end
      REQ: begin
        mem_rd   = 1'b1;
        mem_addr = {eff_reg[31:2], 2'b00};
        if (cnt_reg == LAT) begin
          rdata_next = extracted;
          fault_next = 1'b0;
          cnt_next   = 3'd0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      DONE: begin
        done       = 1'b1;
        fault      = fault_reg;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
      eff_reg   <= 32'h0000_0000;
      mode_reg  <= 3'd0;
      fault_reg <= 1'b0;
      rdata_reg <= 32'h0000_0000;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      eff_reg   <= eff_next;
      mode_reg  <= mode_next;
      fault_reg <= fault_next;
      rdata_reg <= rdata_next;
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: tb/tb_mem_load_unit.sv
// Bench for mem_load_unit: two instances (latency 1 and 3) checked every cycle
// against a transaction-timeline model, plus literal expectations.
`timescale 1ns/1ps
module tb_mem_load_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [1:0]        start_v;
  logic [1:0][2:0]   mode_v;
  logic [1:0][31:0]  addr_v;
  logic [1:0][1:0]   exc_v;
  logic [1:0][31:0]  mem_addr_v;
  logic [1:0][31:0]  rdata_v;
  logic [1:0]        mem_rd_v, busy_v, done_v, fault_v;

  logic [31:0] mem [256];
  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [31:0] mem_rdata_l;
    int rdcnt = 0;

    mem_load_unit #(.READ_LATENCY((gi == 0) ? 1 : 3)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start_v[gi]),
      .mode      (mode_v[gi]),
      .addr      (addr_v[gi]),
      .exc_sel   (exc_v[gi]),
      .mem_rdata (mem_rdata_l),
      .mem_addr  (mem_addr_v[gi]),
      .mem_rd    (mem_rd_v[gi]),
      .busy      (busy_v[gi]),
      .done      (done_v[gi]),
      .fault     (fault_v[gi]),
      .rdata     (rdata_v[gi])
    );

    // Memory returns real data only in the L-th cycle of a read; garbage otherwise.
    always @(negedge clk) begin
      if (mem_rd_v[gi] === 1'b1) rdcnt = rdcnt + 1;
      else rdcnt = 0;
      mem_rdata_l = (rdcnt == lat_of(gi)) ? mem[mem_addr_v[gi][9:2]] : $urandom;
    end
  end

  task automatic cmp(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s inst=%0d got=%h expected=%h t=%0t", name, i, act, exp, $time);
    end
  endtask

  // Reference rules
  function automatic void decode(input logic [2:0] m, input logic [31:0] a, input logic [1:0] e,
                                 output logic ill, output logic [31:0] eff);
    ill = 1'b0;
    eff = a;
    case (m)
      3'd0: ill = (a % 4) != 0;
      3'd1, 3'd2: ill = (a % 2) != 0;
      3'd3, 3'd4: ill = 1'b0;
      3'd5: begin
        if (e == 2'd3) ill = 1'b1;
        else eff = 32'hFD + 32'(e);
      end
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] expect_val(input logic [2:0] m, input logic [31:0] eff);
    logic [31:0] w;
    int sh, b, h, r;
    w  = mem[eff[9:2]];
    sh = int'(eff % 4);
    b  = int'((w >> (8 * sh)) & 32'hFF);
    h  = (sh >= 2) ? int'((w >> 16) & 32'hFFFF) : int'(w & 32'hFFFF);
    case (m)
      3'd0: r = int'(w);
      3'd1: r = (h >= 32768) ? h - 65536 : h;
      3'd2: r = h;
      3'd3: r = (b >= 128) ? b - 256 : b;
      default: r = b;
    endcase
    return 32'(r);
  endfunction

  // Timeline model: t = cycles since acceptance, 0 when idle.
  int          t_m [2]       = '{0, 0};
  int          done_at_m [2] = '{1, 1};
  logic        ill_m [2]     = '{1'b0, 1'b0};
  logic [31:0] word_m [2]    = '{32'h0, 32'h0};
  logic [31:0] val_m [2]     = '{32'h0, 32'h0};
  logic [31:0] rdata_m [2]   = '{32'h0, 32'h0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        t_m[i]     = 0;
        rdata_m[i] = 32'h0;
      end else if (t_m[i] == 0) begin
        if (start_v[i]) begin
          logic        ill;
          logic [31:0] eff;
          decode(mode_v[i], addr_v[i], exc_v[i], ill, eff);
          ill_m[i]     = ill;
          word_m[i]    = {eff[31:2], 2'b00};
          val_m[i]     = ill ? 32'h0 : expect_val(mode_v[i], eff);
          done_at_m[i] = ill ? 1 : lat_of(i) + 1;
          t_m[i]       = 1;
          if (t_m[i] == done_at_m[i]) rdata_m[i] = val_m[i];
        end
      end else begin
        t_m[i] = t_m[i] + 1;
        if (t_m[i] > done_at_m[i]) t_m[i] = 0;
        else if (t_m[i] == done_at_m[i]) rdata_m[i] = val_m[i];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic e_busy, e_done, e_rd;
        e_busy = (t_m[i] != 0);
        e_done = e_busy && (t_m[i] == done_at_m[i]);
        e_rd   = e_busy && !ill_m[i] && (t_m[i] <= lat_of(i));
        cmp("busy", i, 32'(busy_v[i]), 32'(e_busy));
        cmp("done", i, 32'(done_v[i]), 32'(e_done));
        cmp("fault", i, 32'(fault_v[i]), 32'(e_done && ill_m[i]));
        cmp("mem_rd", i, 32'(mem_rd_v[i]), 32'(e_rd));
        cmp("mem_addr", i, mem_addr_v[i], e_rd ? word_m[i] : 32'h0);
        cmp("rdata", i, rdata_v[i], rdata_m[i]);
      end
    end
  end

  // Issue one request from an idle negedge; returns in the following idle cycle.
  task automatic run(input int i, input logic [2:0] m, input logic [31:0] a, input logic [1:0] e,
                     input bit scramble, output logic [31:0] r, output logic f, output int lat);
    start_v[i] = 1'b1;
    mode_v[i]  = m;
    addr_v[i]  = a;
    exc_v[i]   = e;
    @(negedge clk);
    start_v[i] = 1'b0;
    mode_v[i]  = 3'($urandom);
    addr_v[i]  = $urandom;
    exc_v[i]   = 2'($urandom);
    lat = 1;
    while (!done_v[i] && lat < 20) begin
      if (scramble) start_v[i] = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    start_v[i] = 1'b0;
    if (!done_v[i]) cmp("done_timeout", i, 32'(done_v[i]), 32'h1);
    r = rdata_v[i];
    f = fault_v[i];
    $display("txn inst=%0d mode=%0d addr=%h exc=%0d rdata=%h fault=%0d cycles=%0d",
             i, m, a, e, r, f, lat);
    @(negedge clk);
  endtask

  task automatic dchk(input int i, input logic [2:0] m, input logic [31:0] a, input logic [1:0] e,
                      input logic [31:0] exp_r, input logic exp_f);
    logic [31:0] r;
    logic        f;
    int          lat;
    run(i, m, a, e, 1'b0, r, f, lat);
    cmp("rdata_lit", i, r, exp_r);
    cmp("fault_lit", i, 32'(f), 32'(exp_f));
    cmp("latency_lit", i, 32'(lat), exp_f ? 32'd1 : 32'(lat_of(i) + 1));
  endtask

  task automatic b2b(input int i);
    int n, span;
    n = 0;
    span = 3 * (lat_of(i) + 2);
    start_v[i] = 1'b1;
    mode_v[i]  = 3'd0;
    addr_v[i]  = 32'h100;
    exc_v[i]   = 2'd0;
    for (int j = 0; j < span; j++) begin
      @(negedge clk);
      if (done_v[i]) n++;
    end
    start_v[i] = 1'b0;
    $display("txn inst=%0d back-to-back lw 0x100 dones=%0d over %0d cycles", i, n, span);
    cmp("b2b_dones", i, 32'(n), 32'd3);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog inst=0 got=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic        f;
    int          lat;
    reset   = 1'b1;
    start_v = '0;
    mode_v  = '0;
    addr_v  = '0;
    exc_v   = '0;
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    mem[32'h100 >> 2] = 32'h80FF7F01;
    mem[32'hFC >> 2]  = 32'hD0C0B0A0;

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cmp("reset_busy", i, 32'(busy_v[i]), 32'h0);
      cmp("reset_done", i, 32'(done_v[i]), 32'h0);
      cmp("reset_mem_rd", i, 32'(mem_rd_v[i]), 32'h0);
      cmp("reset_mem_addr", i, mem_addr_v[i], 32'h0);
      cmp("reset_rdata", i, rdata_v[i], 32'h0);
    end
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      dchk(i, 3'd0, 32'h100, 2'd0, 32'h80FF7F01, 1'b0);
      dchk(i, 3'd3, 32'h102, 2'd0, 32'hFFFFFFFF, 1'b0);
      dchk(i, 3'd4, 32'h102, 2'd0, 32'h000000FF, 1'b0);
      dchk(i, 3'd1, 32'h102, 2'd0, 32'hFFFF80FF, 1'b0);
      dchk(i, 3'd2, 32'h100, 2'd0, 32'h00007F01, 1'b0);
      dchk(i, 3'd5, 32'h0,   2'd0, 32'h000000B0, 1'b0);
      dchk(i, 3'd5, 32'h0,   2'd1, 32'h000000C0, 1'b0);
      dchk(i, 3'd5, 32'h0,   2'd2, 32'h000000D0, 1'b0);
      dchk(i, 3'd0, 32'h102, 2'd0, 32'h0, 1'b1);
      dchk(i, 3'd1, 32'h101, 2'd0, 32'h0, 1'b1);
      dchk(i, 3'd6, 32'h100, 2'd0, 32'h0, 1'b1);
      dchk(i, 3'd5, 32'h0,   2'd3, 32'h0, 1'b1);
      b2b(i);
    end

    // Abort an L=3 read in its second cycle; start alongside reset is ignored.
    start_v[1] = 1'b1;
    mode_v[1]  = 3'd0;
    addr_v[1]  = 32'h100;
    @(negedge clk);
    start_v[1] = 1'b0;
    @(negedge clk);
    reset      = 1'b1;
    start_v[1] = 1'b1;
    mode_v[1]  = 3'd2;
    @(negedge clk);
    cmp("abort_busy", 1, 32'(busy_v[1]), 32'h0);
    cmp("abort_mem_rd", 1, 32'(mem_rd_v[1]), 32'h0);
    cmp("abort_done", 1, 32'(done_v[1]), 32'h0);
    cmp("abort_rdata", 1, rdata_v[1], 32'h0);
    reset      = 1'b0;
    start_v[1] = 1'b0;
    $display("txn inst=1 reset during read");
    repeat (4) @(negedge clk);
    dchk(1, 3'd2, 32'h100, 2'd0, 32'h00007F01, 1'b0);

    for (int n = 0; n < 120; n++) begin
      int          i;
      logic [2:0]  m;
      logic [31:0] a;
      i = $urandom_range(0, 1);
      m = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) m = 3'($urandom_range(0, 5));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (m == 3'd0) a[1:0] = 2'b00;
        else if (m == 3'd1 || m == 3'd2) a[0] = 1'b0;
      end
      run(i, m, a, 2'($urandom), 1'b1, r, f, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_load_unit.md
# mem_load_unit

Read-side companion to the datapath's memory-address/write-data selection. It performs one memory read per request and returns a register-ready 32-bit value: a word, a sign- or zero-extended halfword or byte, or an exception-handler address. The exception-handler address is the zero-extended byte stored at 0xFD, 0xFE or 0xFF. It sits between the control FSM (request/done handshake) and the byte-addressed memory, which has a fixed read latency, and replaces ad-hoc MDR capture and extension logic.

## Interface
- READ_LATENCY, 1, cycles from `mem_rd`/`mem_addr` first presented to `mem_rdata` valid; legal range 1..4.

- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request strobe; sampled only in IDLE.
- mode  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 exception-vector fetch; 110/111 illegal.
- addr  in  32  byte address (ignored for mode 101).
- exc_sel  in  2  for mode 101: 00 → 0xFD (invalid opcode), 01 → 0xFE (overflow), 10 → 0xFF (divide by zero), 11 illegal.
- mem_rdata  in  32  memory word; byte k at bits [8k+7:8k].
- mem_addr  out  32  word-aligned read address.
- mem_rd  out  1  read enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- fault  out  1  valid with `done`: misaligned or illegal request.
- rdata  out  32  result; holds until the next `done`.

## Operation
- States: IDLE, REQ, DONE.
- IDLE, start=1, request legal → latch the effective byte address, mode and extension type; enter REQ with the latency counter at 1.
  - Effective address is `addr` for modes 000–100, or 0xFD/0xFE/0xFF for mode 101.
- IDLE, start=1, request illegal → enter DONE directly with fault=1 and rdata=0. No memory access is made. Illegal requests:
  - lw with addr[1:0]≠0.
  - lh/lhu with addr[0]≠0.
  - mode 110/111.
  - mode 101 with exc_sel=11.
- REQ: mem_rd=1, mem_addr={eff[31:2],2'b00}, both stable for the whole state.
  - The counter increments each cycle.
  - When the counter equals READ_LATENCY, sample mem_rdata, extract, register into rdata and enter DONE.
- Extraction, with lane = eff[1:0]:
  - lw: the whole word.
  - lh: bits [16·lane[1]+15 : 16·lane[1]], sign-extended; lhu zero-extends the same field.
  - lb: byte `lane`, sign-extended; lbu zero-extends it.
  - mode 101: byte `lane`, zero-extended.
- DONE: done=1 for exactly one cycle. fault=1 only for illegal requests, otherwise 0. Return to IDLE next cycle.
- start outside IDLE is ignored; it is not queued.
- Outside REQ: mem_rd=0, mem_addr=0.

## Timing
- Reset values: state IDLE, counter 0; mem_rd, done, fault, busy all 0; mem_addr 0; rdata 0.
- Legal request, start sampled at edge E0:
  - REQ occupies cycles 1..L (L = READ_LATENCY); mem_rdata is sampled at edge E_L.
  - done and the new rdata are visible in cycle L+1.
  - IDLE in cycle L+2; the next start may be sampled at that edge (throughput one read per L+2 cycles).
- Illegal request: done=1, fault=1 in cycle 1; IDLE in cycle 2; mem_rd never asserts.
- rdata updates only on the edge entering DONE: the extracted value for a legal request, 0 for a fault. Otherwise it holds.
- reset during REQ or DONE:
  - Next cycle is IDLE with all outputs at reset values.
  - No done pulse is issued for the aborted request; rdata is cleared to 0.
- start asserted together with reset is ignored.
- mode/addr/exc_sel are don't-care after the accepting edge; changes during REQ have no effect.

## Test plan
Memory preload for all scenarios: word 0x100 = 0x80FF7F01, word 0xFC = 0xD0C0B0A0.

- lw addr=0x100, L=1 → mem_rd high in cycle 1 only; mem_addr=0x100; done in cycle 2; rdata=0x80FF7F01; fault=0.
- lb 0x102 → 0xFFFFFFFF; lbu 0x102 → 0x000000FF; lh 0x102 → 0xFFFF80FF; lhu 0x100 → 0x00007F01. Repeat all four with L=3: done in cycle 4, mem_addr stable cycles 1..3.
- Mode 101 with exc_sel=00/01/10 → mem_addr=0xFC; rdata=0x000000B0 / 0x000000C0 / 0x000000D0.
- lw addr=0x102; lh addr=0x101; mode 110; mode 101 with exc_sel=11 → each gives done+fault in cycle 1, rdata=0, mem_rd never 1.
- Back-to-back: start held high continuously with lw 0x100 → done pulses every L+2 cycles. Extra start pulses during REQ/DONE produce no extra done.
- reset asserted in cycle 2 of an L=3 read → next cycle IDLE, busy=0, mem_rd=0, rdata=0, no done. A new lhu 0x100 afterwards completes normally with rdata=0x00007F01.
